// File: rtl/mux_share_arb_if.sv
// Handshake and datapath bundle for mux_share_arb: two requesters, one
// registered output channel and the per-source grant counters.
interface mux_share_arb_if #(
  parameter int W  = 64,
  parameter int CW = 16
);
  logic          a_valid;
  logic [W-1:0]  a_data;
  logic          a_ready;
  logic          b_valid;
  logic [W-1:0]  b_data;
  logic          b_ready;
  logic          sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_src;
  logic          out_ready;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  // Arbiter side
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data, out_src, cnt_a, cnt_b
  );

  // Requester / consumer side
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data, out_src, cnt_a, cnt_b
  );
endinterface

// File: rtl/mux_share_arb.sv
// Two-requester round-robin arbiter sharing one 2:1 mux into a one-entry
// output register. A tie goes to the source that did not win last time.
module mux_share_arb #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  mux_share_arb_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_p1, state_d;
  logic          last_a_p1;      // 1: last grant went to A, 0: to B
  logic [W-1:0]  data_p1;
  logic          src_p1;
  logic [CW-1:0] cnt_a_p1, cnt_b_p1;

  logic win_a, win_b, space, accept;

  // Winner selection, handshake readies and output-register next state
  always_comb begin
    state_d = state_p1;
    win_a   = bus.a_valid & (~bus.b_valid | ~last_a_p1);
    win_b   = bus.b_valid & (~bus.a_valid |  last_a_p1);
    space   = (state_p1 == EMPTY) | bus.out_ready;
    bus.sel     = win_a;
    bus.a_ready = win_a & space & ~reset;
    bus.b_ready = win_b & space & ~reset;
    accept      = bus.a_ready | bus.b_ready;
    if (accept) begin
      state_d = FULL;
    end else if ((state_p1 == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register occupancy and round-robin priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= EMPTY;
      last_a_p1 <= 1'b0;
    end else begin
      state_p1 <= state_d;
      if (accept) last_a_p1 <= win_a;
    end
  end

  // ---- stage p1: registered mux result and its source tag ----
  // Captures the winning word; holds across drain-only and stalled edges
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= '0;
      src_p1  <= 1'b0;
    end else if (accept) begin
      data_p1 <= win_a ? bus.a_data : bus.b_data;
      src_p1  <= win_a;
    end
  end

  // Per-source grant counters, wrapping modulo 2^CW
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_p1 <= '0;
      cnt_b_p1 <= '0;
    end else begin
      if (bus.a_ready) cnt_a_p1 <= cnt_a_p1 + 1'b1;
      if (bus.b_ready) cnt_b_p1 <= cnt_b_p1 + 1'b1;
    end
  end

  assign bus.out_valid = (state_p1 == FULL);
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.cnt_a     = cnt_a_p1;
  assign bus.cnt_b     = cnt_b_p1;

endmodule

// File: tb/tb_mux_share_arb.sv
// Self-checking bench for mux_share_arb: directed scenarios plus a
// randomized run, with a reference model and an output scoreboard.
module tb_mux_share_arb;
  localparam int W  = 64;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_share_arb_if #(.W(W), .CW(CW)) bus ();

  mux_share_arb #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: output occupancy, who won last, grant totals
  bit        m_full   = 1'b0;
  bit        m_last_a = 1'b0;
  int        m_cnt_a  = 0;
  int        m_cnt_b  = 0;
  bit        m_acc_a  = 1'b0;
  bit        m_acc_b  = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: every word the consumer takes must be the oldest expected
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain_unexpected: got %h required no word at %0t", bus.out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.d);
        check("out_src", {{(W-1){1'b0}}, bus.out_src}, {{(W-1){1'b0}}, e.s});
      end
    end
  end

  // One clock of traffic: drive, predict and check combinational outputs,
  // then advance the model across the edge.
  task automatic cycle(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic ordy);
    bit win_a, win_b, space;
    exp_t e;
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
    @(negedge clk);
    // Round robin: sole requester wins; on a tie, whoever did not win last
    if (av && bv) begin
      win_a = !m_last_a;
      win_b = m_last_a;
    end else begin
      win_a = av;
      win_b = bv;
    end
    space = !m_full || ordy;
    m_acc_a = win_a && space;
    m_acc_b = win_b && space;
    check("a_ready", {63'd0, bus.a_ready}, {63'd0, m_acc_a});
    check("b_ready", {63'd0, bus.b_ready}, {63'd0, m_acc_b});
    check("sel", {63'd0, bus.sel}, {63'd0, win_a});
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_full});
    check("cnt_a", {60'd0, bus.cnt_a}, 64'(m_cnt_a % 16));
    check("cnt_b", {60'd0, bus.cnt_b}, 64'(m_cnt_b % 16));
    if (bus.a_ready && bus.b_ready) check("both_ready", 64'd1, 64'd0);
    if (m_acc_a) begin e.d = ad; e.s = 1'b1; exp_q.push_back(e); end
    if (m_acc_b) begin e.d = bd; e.s = 1'b0; exp_q.push_back(e); end
    @(posedge clk);
    if (m_acc_a || m_acc_b) begin
      m_full   = 1'b1;
      m_last_a = m_acc_a;
      if (m_acc_a) m_cnt_a++;
      else         m_cnt_b++;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Two reset cycles: first with live requests (readies must stay low),
  // then idle, after which every output is at its reset value.
  task automatic do_reset();
    reset         = 1'b1;
    bus.a_valid   = 1'b1;
    bus.a_data    = 64'h5555;
    bus.b_valid   = 1'b1;
    bus.b_data    = 64'h6666;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_a_ready", {63'd0, bus.a_ready}, 64'd0);
    check("rst_b_ready", {63'd0, bus.b_ready}, 64'd0);
    @(posedge clk);
    m_full = 1'b0; m_last_a = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    exp_q.delete();
    #1;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_src", {63'd0, bus.out_src}, 64'd0);
    check("rst_cnt_a", {60'd0, bus.cnt_a}, 64'd0);
    check("rst_cnt_b", {60'd0, bus.cnt_b}, 64'd0);
    check("rst_sel", {63'd0, bus.sel}, 64'd0);
    check("rst_idle_a_ready", {63'd0, bus.a_ready}, 64'd0);
    check("rst_idle_b_ready", {63'd0, bus.b_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic         av, bv;
    logic [W-1:0] ad, bd;
    logic         ordy;

    do_reset();

    // Tie with the consumer always ready: A, B, A, B
    repeat (4) cycle(1'b1, 64'h1111, 1'b1, 64'h2222, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("tie_cnt_a", {60'd0, bus.cnt_a}, 64'd2);
    check("tie_cnt_b", {60'd0, bus.cnt_b}, 64'd2);

    // Backpressure: DEAD is held while the consumer stalls
    do_reset();
    cycle(1'b1, 64'hDEAD, 1'b0, '0, 1'b0);
    repeat (3) begin
      cycle(1'b1, 64'hF00D, 1'b0, '0, 1'b0);
      check("bp_hold_data", bus.out_data, 64'hDEAD);
      check("bp_cnt_a", {60'd0, bus.cnt_a}, 64'd1);
    end
    cycle(1'b1, 64'hF00D, 1'b0, '0, 1'b1);

    // Simultaneous drain and accept from B, no bubble
    cycle(1'b0, '0, 1'b1, 64'hBEEF, 1'b1);
    check("swap_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("swap_out_data", bus.out_data, 64'hBEEF);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Counter wrap with CW = 4: 17 accepts leaves 1
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, 64'(i + 100), 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("wrap_cnt_a", {60'd0, bus.cnt_a}, 64'd1);
    check("wrap_cnt_b", {60'd0, bus.cnt_b}, 64'd0);

    // Random run; requests stay stable until the model sees them accepted
    do_reset();
    av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
    for (int i = 0; i < 200; i++) begin
      if (!av || m_acc_a) begin
        av = 1'($urandom_range(0, 1));
        ad = {$urandom, $urandom};
      end
      if (!bv || m_acc_b) begin
        bv = 1'($urandom_range(0, 1));
        bd = {$urandom, $urandom};
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(av, ad, bv, bd, ordy);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("random_leftover", 64'(exp_q.size()), 64'd0);

    // Reset while FULL discards the held word
    cycle(1'b1, 64'hCAFE, 1'b0, '0, 1'b0);
    check("full_before_reset", {63'd0, bus.out_valid}, 64'd1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
